// File: rtl/sram_ahbl_rw.sv
// AHB-Lite SRAM slave with byte-lane writes, wait states and error responses.
// Read data is registered at acceptance and forwarded on same-word RAW.
module sram_ahbl_rw #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH-1:0] ahbl_haddr,
    input  logic [2:0]            ahbl_hburst,
    input  logic                  ahbl_hmastlock,
    input  logic [3:0]            ahbl_hprot,
    input  logic [2:0]            ahbl_hsize,
    input  logic [1:0]            ahbl_htrans,
    input  logic [DATA_WIDTH-1:0] ahbl_hwdata,
    input  logic                  ahbl_hwrite,
    output logic [DATA_WIDTH-1:0] ahbl_hrdata,
    output logic                  ahbl_hready,
    output logic                  ahbl_hresp
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int BO = $clog2(NB);
    localparam int IW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(DEPTH * NB);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic [IW-1:0]         r_idx;
    logic [NB-1:0]         r_mask;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_hrdata;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_hready;
    logic                  w_hresp;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_off;
    logic [ADDR_WIDTH-1:0] w_amask;
    logic                  w_in_range;
    logic                  w_oversize;
    logic                  w_misal;
    logic                  w_err;
    logic [IW-1:0]         w_idx;
    logic [BO-1:0]         w_lo;
    logic [NB-1:0]         w_mask;
    logic                  w_wr_fire;
    logic                  w_rd_acc;
    logic [DATA_WIDTH-1:0] w_mem_rd;
    logic [DATA_WIDTH-1:0] w_fwd;
    logic                  w_unused;

    assign w_unused = ^{ahbl_hburst, ahbl_hmastlock, ahbl_hprot, ahbl_htrans[0]};

    assign ahbl_hready = w_hready;
    assign ahbl_hresp  = w_hresp;
    assign ahbl_hrdata = r_hrdata;

    // Address-phase decode
    assign w_off      = ahbl_haddr - BASE_ADDR;
    assign w_in_range = (ahbl_haddr >= BASE_ADDR) && (w_off < SPAN);
    assign w_oversize = ahbl_hsize > 3'(BO);
    assign w_amask    = (ADDR_WIDTH'(1) << ahbl_hsize) - ADDR_WIDTH'(1);
    assign w_misal    = |(ahbl_haddr & w_amask);
    assign w_err      = !w_in_range || w_oversize || w_misal;
    assign w_idx      = w_off[BO+IW-1:BO];
    assign w_lo       = ahbl_haddr[BO-1:0];

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NB; i++) begin
            w_mask[i] = (i >= int'(w_lo)) &&
                        (i < int'(w_lo) + (1 << ahbl_hsize));
        end
    end

    always_comb begin
        w_hready = 1'b1;
        w_hresp  = 1'b0;
        unique case (r_state)
            S_DATA: w_hready = (r_cnt == 4'd0);
            S_ERR1: begin
                w_hready = 1'b0;
                w_hresp  = 1'b1;
            end
            S_ERR2: w_hresp = 1'b1;
            default: ;
        endcase
    end

    assign w_accept  = w_hready && ahbl_htrans[1];
    assign w_rd_acc  = w_accept && !w_err && !ahbl_hwrite;
    assign w_wr_fire = (r_state == S_DATA) && w_hready && r_write;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_ERR1:  w_state_nxt = S_ERR2;
            S_DATA:  if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
            default: ;
        endcase
        if (w_hready) begin
            w_cnt_nxt = 4'd0;
            if (!w_accept) begin
                w_state_nxt = S_IDLE;
            end else if (w_err) begin
                w_state_nxt = S_ERR1;
            end else begin
                w_state_nxt = S_DATA;
                w_cnt_nxt   = WS;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idx   <= '0;
            r_mask  <= '0;
            r_write <= 1'b0;
        end else if (w_hready) begin
            r_idx   <= w_idx;
            r_mask  <= w_mask;
            r_write <= w_accept && !w_err && ahbl_hwrite;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            for (int i = 0; i < NB; i++) begin
                if (r_mask[i]) r_mem[r_idx][8*i +: 8] <= ahbl_hwdata[8*i +: 8];
            end
        end
    end

    // A write completing on this edge is merged so the read is never stale
    assign w_mem_rd = r_mem[w_idx];

    always_comb begin
        w_fwd = w_mem_rd;
        for (int i = 0; i < NB; i++) begin
            if (r_mask[i]) w_fwd[8*i +: 8] = ahbl_hwdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hrdata <= '0;
        end else if (w_rd_acc) begin
            r_hrdata <= (w_wr_fire && (r_idx == w_idx)) ? w_fwd : w_mem_rd;
        end
    end

endmodule

// File: tb/tb_sram_ahbl_rw.sv
// Bench for sram_ahbl_rw: three instances (0, 2 and 3 wait states)
// share one bus; a scoreboard holds the expected hrdata per transfer.
module tb_sram_ahbl_rw;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  sz;
        logic [31:0] data;
        logic        err;
    } tx_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic        hwrite;
    int          sel;

    logic [31:0] rd_o  [3];
    logic        rdy_o [3];
    logic        rsp_o [3];
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    int n_chk  = 0;
    int n_pass = 0;

    tx_t         txq [$];
    logic [31:0] sbq [$];
    logic [31:0] m_mem [int];
    logic [31:0] m_rd [3];

    always #5 clk = ~clk;

    assign hrdata = rd_o[sel];
    assign hready = rdy_o[sel];
    assign hresp  = rsp_o[sel];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sram_ahbl_rw #(
            .WAIT_STATES(g == 0 ? 0 : g + 1)
        ) u_dut (
            .clk           (clk),
            .rstn          (rstn),
            .ahbl_haddr    (haddr),
            .ahbl_hburst   (3'b000),
            .ahbl_hmastlock(1'b0),
            .ahbl_hprot    (4'h3),
            .ahbl_hsize    (hsize),
            .ahbl_htrans   (sel == g ? htrans : 2'b00),
            .ahbl_hwdata   (hwdata),
            .ahbl_hwrite   (hwrite),
            .ahbl_hrdata   (rd_o[g]),
            .ahbl_hready   (rdy_o[g]),
            .ahbl_hresp    (rsp_o[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic tx_t mk(input logic wr, input logic [31:0] addr,
                               input logic [2:0] sz, input logic [31:0] data,
                               input logic err);
        tx_t t;
        t.wr = wr; t.addr = addr; t.sz = sz; t.data = data; t.err = err;
        return t;
    endfunction

    function automatic int ws_of(input int s);
        return (s == 0) ? 0 : s + 1;
    endfunction

    task automatic model_drive(input tx_t t);
        int          key;
        logic [3:0]  lanes;
        logic [31:0] w;
        key = sel * 4096 + int'(t.addr >> 2);
        if (!t.err && t.wr) begin
            lanes = 4'(((1 << (1 << t.sz)) - 1) << t.addr[1:0]);
            w = m_mem.exists(key) ? m_mem[key] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (lanes[b]) w[8*b +: 8] = t.data[8*b +: 8];
            m_mem[key] = w;
        end else if (!t.err) begin
            m_rd[sel] = m_mem.exists(key) ? m_mem[key] : 32'h0;
        end
        sbq.push_back(m_rd[sel]);
    endtask

    // Pipelined driver: address phase of k overlaps data phase of k-1
    task automatic run();
        tx_t cur;
        tx_t prv;
        bit  have_prv;
        int  n;
        int  lows;
        n = txq.size();
        have_prv = 0;
        cur = mk(0, 0, 0, 0, 0);
        prv = cur;
        for (int k = 0; k <= n; k++) begin
            if (k < n) begin
                cur = txq[k];
                htrans = 2'b10;
                haddr  = cur.addr;
                hwrite = cur.wr;
                hsize  = cur.sz;
                model_drive(cur);
            end else begin
                htrans = 2'b00;
                haddr  = 32'h0;
                hwrite = 1'b0;
                hsize  = 3'd0;
            end
            hwdata = (have_prv && prv.wr) ? prv.data : 32'h0;
            lows = 0;
            for (int c = 0; c <= 40; c++) begin
                @(negedge clk);
                if (have_prv) begin
                    chk("hresp", 32'(hresp), 32'(prv.err));
                    if (sbq.size() > 0) chk("hrdata", hrdata, sbq[0]);
                end
                if (hready) break;
                lows++;
                if (c == 40) chk("timeout", 32'd1, 32'd0);
            end
            if (have_prv) begin
                chk("waits", 32'(lows), prv.err ? 32'd1 : 32'(ws_of(sel)));
                if (sbq.size() > 0) void'(sbq.pop_front());
            end
            @(posedge clk);
            #1;
            prv = cur;
            have_prv = (k < n);
        end
        txq.delete();
    endtask

    initial begin
        rstn = 1'b0;
        sel = 0;
        haddr = 0; hwdata = 0; hsize = 0; htrans = 0; hwrite = 0;
        for (int s = 0; s < 3; s++) m_rd[s] = 32'h0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("rst_hready", 32'(hready), 32'd1);
            chk("rst_hresp", 32'(hresp), 32'd0);
            chk("rst_hrdata", hrdata, 32'h0);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        sel = 0;
        txq.push_back(mk(1, 32'h10, 2, 32'hDEADBEEF, 0));
        txq.push_back(mk(0, 32'h10, 2, 32'h0, 0));
        run();
        txq.push_back(mk(1, 32'h10, 2, 32'h11223344, 0));
        txq.push_back(mk(1, 32'h11, 0, 32'h0000AA00, 0));
        txq.push_back(mk(0, 32'h10, 2, 32'h0, 0));
        txq.push_back(mk(1, 32'h12, 1, 32'h55660000, 0));
        txq.push_back(mk(0, 32'h10, 2, 32'h0, 0));
        run();
        txq.push_back(mk(1, 32'h20, 2, 32'hCAFEF00D, 0));
        txq.push_back(mk(0, 32'h20, 2, 32'h0, 0));
        run();
        txq.push_back(mk(0, 32'h1000, 2, 32'h0, 1));
        txq.push_back(mk(0, 32'h22, 2, 32'h0, 1));
        txq.push_back(mk(0, 32'h18, 3, 32'h0, 1));
        txq.push_back(mk(1, 32'h12, 2, 32'hFFFFFFFF, 1));
        txq.push_back(mk(1, 32'h1000, 2, 32'hFFFFFFFF, 1));
        txq.push_back(mk(0, 32'h10, 2, 32'h0, 0));
        txq.push_back(mk(0, 32'h20, 2, 32'h0, 0));
        run();

        sel = 1;
        txq.push_back(mk(1, 32'h30, 2, 32'h0BADCAFE, 0));
        txq.push_back(mk(0, 32'h30, 2, 32'h0, 0));
        txq.push_back(mk(1, 32'h33, 0, 32'h77000000, 0));
        txq.push_back(mk(0, 32'h30, 2, 32'h0, 0));
        txq.push_back(mk(0, 32'h31, 0, 32'h0, 0));
        run();

        sel = 2;
        txq.push_back(mk(1, 32'h40, 2, 32'h12345678, 0));
        txq.push_back(mk(0, 32'h40, 2, 32'h0, 0));
        run();
        htrans = 2'b10; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2;
        @(negedge clk);
        chk("t6_accept_rdy", 32'(hready), 32'd1);
        @(posedge clk);
        #1;
        htrans = 2'b00; hwrite = 1'b0; hwdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("t6_wait_rdy", 32'(hready), 32'd0);
        chk("t6_pre_rdata", hrdata, 32'h12345678);
        rstn = 1'b0;
        #1;
        chk("t6_rst_rdy", 32'(hready), 32'd1);
        chk("t6_rst_resp", 32'(hresp), 32'd0);
        chk("t6_rst_rdata", hrdata, 32'h0);
        for (int s = 0; s < 3; s++) m_rd[s] = 32'h0;
        @(negedge clk);
        rstn = 1'b1;
        hwdata = 32'h0;
        @(posedge clk);
        #1;
        txq.push_back(mk(0, 32'h40, 2, 32'h0, 0));
        run();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
